multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multicycle sequencer for the single-datapath MIPS-subset core. It walks each instruction through fetch, decode, execute, memory and writeback states and drives every datapath enable and mux select. It waits on a shared instruction/data memory ready handshake, with a watchdog on that wait. It counts retired instructions and halts on illegal opcodes or memory timeouts.

Parameters:
RETW, 32, width of retired-instruction counter
MAXWAIT, 255, max cycles a memory wait state may last before timeout (1..2^WAITW-1)
WAITW, 8, width of wait counter

Ports:
clock  in  1  rising-edge clock
resetN  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from instruction register (valid from DECODE onward)
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
memReady  in  1  memory completes current read/write this cycle
pcWrite  out  1  PC register load enable
pcSrc  out  2  00 ALU result (pc+4), 01 ALUOut (branch target), 10 jump target, 11 RD1 (jr)
irWrite  out  1  instruction register load
iOrD  out  1  memory address: 0 PC, 1 ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
regWrite  out  1  register file write enable
regDst  out  2  00 rt, 01 rd, 10 r31
memToReg  out  2  00 ALUOut, 01 memory data, 10 PC (already pc+4)
aluSrcA  out  1  0 PC, 1 RD1
aluSrcB  out  2  00 RD2, 01 constant 4, 10 signImm, 11 signImm<<2
aluControl  out  5  00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLT
state  out  4  current state encoding (debug)
retired  out  RETW  instructions completed, wraps modulo 2^RETW
illegal  out  1  sticky: unsupported opcode/funct decoded
timeout  out  1  sticky: memory wait exceeded MAXWAIT

Behaviour:
- Reset (async, resetN=0): state=FETCH(0), retired=0, illegal=0, timeout=0, waitCnt=0. All strobes (pcWrite, irWrite, memRead, memWrite, regWrite) forced 0 while resetN=0. Reset mid-instruction abandons it; retired is not incremented.
- Outputs are Moore decode of state (plus funct in EXEC, zero in BRANCH). Outputs not listed for a state are 0.
- FETCH(0): memRead, iOrD=0, aluSrcA=0, aluSrcB=01, ADD. irWrite and pcWrite (pcSrc=00) are asserted only in the cycle memReady=1, then next state is DECODE. Otherwise stay in FETCH.
- DECODE(1): aluSrcA=0, aluSrcB=11, ADD. Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 with funct 100000/100010/100100/100101/101010 -> EXEC
  - 000000 with funct 001000 -> JR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - 000011 -> JAL
  - anything else -> HALT with illegal set
- MEMADR(2): aluSrcA=1, aluSrcB=10, ADD. Next is MEMRD for lw, MEMWR for sw.
- MEMRD(3): memRead, iOrD=1. Hold until memReady, then MEMWB.
- MEMWB(4): regWrite, regDst=00, memToReg=01.
- MEMWR(5): memWrite, iOrD=1. Hold until memReady, then FETCH.
- EXEC(6): aluSrcA=1, aluSrcB=00. aluControl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Next is ALUWB(7).
- ALUWB(7): regWrite, regDst=01, memToReg=00.
- BRANCH(8): aluSrcA=1, aluSrcB=00, SUB, pcSrc=01, pcWrite=zero.
- ADDIEX(9): aluSrcA=1, aluSrcB=10, ADD. Next is ADDIWB(10).
- ADDIWB(10): regWrite, regDst=00, memToReg=00.
- JUMP(11): pcWrite, pcSrc=10.
- JAL(12): pcWrite, pcSrc=10, regWrite, regDst=10, memToReg=10.
- JR(13): pcWrite, pcSrc=11.
- HALT(15): all strobes 0. Stays in HALT until reset.
- Return to FETCH: states 4, 5(on memReady), 7, 8, 10, 11, 12, 13 return to FETCH. Each such transition increments retired by 1, wrapping from all-ones to 0.
- Watchdog (wait states FETCH, MEMRD, MEMWR): waitCnt clears on state entry and on memReady, and increments each cycle memReady=0. When waitCnt reaches MAXWAIT with memReady still 0, the next state is HALT and timeout is set. memReady in the same cycle as reaching MAXWAIT wins: the access completes and no timeout occurs.
- Latency with memReady always 1:
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
  - beq, j, jal, jr: 3 cycles

Test Plan:
- Reset, then add (opcode 000000, funct 100000) with memReady=1 -> states 0,1,6,7,0. regWrite=1, regDst=01 in state 7. retired=1 after 4 cycles.
- lw with memReady low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. memRead=1, iOrD=1 throughout MEMRD. regWrite/memToReg=01 in state 4. Total 7 cycles.
- beq with zero=1, then beq with zero=0 -> pcWrite=1, pcSrc=01 in BRANCH for the first; pcWrite=0 for the second. retired increments both times.
- jal -> state 12 asserts pcWrite, pcSrc=10, regWrite, regDst=10, memToReg=10. Then jr (funct 001000) -> state 13 asserts pcSrc=11.
- opcode 111111 -> HALT, illegal=1, state=15, strobes 0 indefinitely. resetN pulse low -> state=0, illegal=0, retired=0.
- MAXWAIT=3, memReady held 0 in FETCH -> HALT after 4 cycles, timeout=1. Repeat with memReady=1 on the 4th cycle -> DECODE, no timeout.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the MIPS-subset core. It walks each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath
// enables and selects. A watchdog guards the memory ready waits, and the
// block counts retired instructions.
module multicycle_control #(
  parameter int RETW    = 32,
  parameter int MAXWAIT = 255,
  parameter int WAITW   = 8
) (
  input  logic            clock,
  input  logic            resetN,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic            zero,
  input  logic            memReady,
  output logic            pcWrite,
  output logic [1:0]      pcSrc,
  output logic            irWrite,
  output logic            iOrD,
  output logic            memRead,
  output logic            memWrite,
  output logic            regWrite,
  output logic [1:0]      regDst,
  output logic [1:0]      memToReg,
  output logic            aluSrcA,
  output logic [1:0]      aluSrcB,
  output logic [4:0]      aluControl,
  output logic [3:0]      state,
  output logic [RETW-1:0] retired,
  output logic            illegal,
  output logic            timeout
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13, S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLT = 5'b00100;

  localparam logic [WAITW-1:0] MAXW = WAITW'(MAXWAIT);

  state_t            state_q, state_d;
  logic [WAITW-1:0]  wait_q, wait_d;
  logic [RETW-1:0]   retired_q, retired_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  logic pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;

  // State, watchdog, retire counter and sticky flags
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state selection; the wait counter only survives a cycle spent
  // waiting in a memory state, so entry and memReady both clear it
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (memReady) begin
          if (state_q == S_FETCH) begin
            state_d = S_DECODE;
          end else if (state_q == S_MEMRD) begin
            state_d = S_MEMWB;
          end else begin
            state_d = S_FETCH;
          end
        end else if (wait_q == MAXW) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WAITW'(1);
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = S_EXEC;
              FN_JR:   state_d = S_JR;
              default: begin
                state_d   = S_HALT;
                illegal_d = 1'b1;
              end
            endcase
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Every entry into FETCH from another state completes an instruction
  always_comb begin
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      retired_d = retired_q + RETW'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Moore output decode (FETCH also looks at memReady, EXEC at funct, BRANCH at zero)
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    pcSrc       = 2'b00;
    iOrD        = 1'b0;
    regDst      = 2'b00;
    memToReg    = 2'b00;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluControl  = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        aluSrcB    = 2'b01;
        pc_write_s = memReady;
        ir_write_s = memReady;
      end
      S_DECODE: aluSrcB = 2'b11;
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_read_s = 1'b1;
        iOrD       = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        memToReg    = 2'b01;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        iOrD        = 1'b1;
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        case (funct)
          FN_SUB:  aluControl = ALU_SUB;
          FN_AND:  aluControl = ALU_AND;
          FN_OR:   aluControl = ALU_OR;
          FN_SLT:  aluControl = ALU_SLT;
          default: aluControl = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        regDst      = 2'b01;
      end
      S_BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_SUB;
        pcSrc      = 2'b01;
        pc_write_s = zero;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_ADDIWB: reg_write_s = 1'b1;
      S_JUMP: begin
        pc_write_s = 1'b1;
        pcSrc      = 2'b10;
      end
      S_JAL: begin
        pc_write_s  = 1'b1;
        pcSrc       = 2'b10;
        reg_write_s = 1'b1;
        regDst      = 2'b10;
        memToReg    = 2'b10;
      end
      S_JR: begin
        pc_write_s = 1'b1;
        pcSrc      = 2'b11;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  // Strobes are held low for as long as reset is asserted
  assign pcWrite  = pc_write_s  & resetN;
  assign irWrite  = ir_write_s  & resetN;
  assign memRead  = mem_read_s  & resetN;
  assign memWrite = mem_write_s & resetN;
  assign regWrite = reg_write_s & resetN;

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model (a list of
// states each instruction class visits), table-driven latency vectors,
// hand-written corner sequences and a randomized run.
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam int RETW    = 4;
  localparam int MAXWAIT = 3;
  localparam int WAITW   = 8;

  logic            clock = 1'b0;
  logic            resetN = 1'b0;
  logic [5:0]      opcode = 6'd0;
  logic [5:0]      funct = 6'd0;
  logic            zero = 1'b0;
  logic            memReady = 1'b0;
  logic            pcWrite, irWrite, iOrD, memRead, memWrite, regWrite, aluSrcA;
  logic [1:0]      pcSrc, regDst, memToReg, aluSrcB;
  logic [4:0]      aluControl;
  logic [3:0]      state;
  logic [RETW-1:0] retired;
  logic            illegal, timeout;

  multicycle_control #(.RETW(RETW), .MAXWAIT(MAXWAIT), .WAITW(WAITW)) dut (
    .clock(clock), .resetN(resetN), .opcode(opcode), .funct(funct),
    .zero(zero), .memReady(memReady), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .irWrite(irWrite), .iOrD(iOrD), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
    .state(state), .retired(retired), .illegal(illegal), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pcWrite;
    logic [1:0] pcSrc;
    logic       irWrite, iOrD, memRead, memWrite, regWrite;
    logic [1:0] regDst, memToReg;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [4:0] aluControl;
  } ctrl_t;

  ctrl_t act_c;
  assign act_c = {pcWrite, pcSrc, irWrite, iOrD, memRead, memWrite, regWrite,
                  regDst, memToReg, aluSrcA, aluSrcB, aluControl};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_seq[$];
  int m_idx, m_wait, m_ret;
  bit m_ill, m_tmo, m_halt;

  function automatic void load_seq(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h23)      m_seq = '{0, 1, 2, 3, 4};
    else if (op == 6'h2b) m_seq = '{0, 1, 2, 5};
    else if (op == 6'h04) m_seq = '{0, 1, 8};
    else if (op == 6'h08) m_seq = '{0, 1, 9, 10};
    else if (op == 6'h02) m_seq = '{0, 1, 11};
    else if (op == 6'h03) m_seq = '{0, 1, 12};
    else if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                             fn == 6'h25 || fn == 6'h2a)) m_seq = '{0, 1, 6, 7};
    else if (op == 6'h00 && fn == 6'h08) m_seq = '{0, 1, 13};
    else m_seq = '{0, 1, 15};
  endfunction

  function automatic int m_state();
    return m_halt ? 15 : m_seq[m_idx];
  endfunction

  function automatic void m_advance();
    m_idx++;
    if (m_idx == m_seq.size()) begin
      m_idx = 0;
      m_ret++;
    end else if (m_seq[m_idx] == 15) begin
      m_halt = 1'b1;
      m_ill  = 1'b1;
    end
  endfunction

  function automatic void model_step(input logic mr);
    int s;
    s = m_state();
    if (m_halt) return;
    if (s == 0 || s == 3 || s == 5) begin
      if (mr) begin
        m_wait = 0;
        m_advance();
      end else if (m_wait == MAXWAIT) begin
        m_wait = 0;
        m_halt = 1'b1;
        m_tmo  = 1'b1;
      end else begin
        m_wait++;
      end
    end else begin
      m_advance();
    end
  endfunction

  function automatic ctrl_t exp_ctrl(input int s, input logic mr, input logic z, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      0:  begin c.memRead = 1'b1; c.aluSrcB = 2'b01; c.pcWrite = mr; c.irWrite = mr; end
      1:  c.aluSrcB = 2'b11;
      2:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      3:  begin c.memRead = 1'b1; c.iOrD = 1'b1; end
      4:  begin c.regWrite = 1'b1; c.memToReg = 2'b01; end
      5:  begin c.memWrite = 1'b1; c.iOrD = 1'b1; end
      6:  begin
            c.aluSrcA = 1'b1;
            if (fn == 6'h22)      c.aluControl = 5'd1;
            else if (fn == 6'h24) c.aluControl = 5'd2;
            else if (fn == 6'h25) c.aluControl = 5'd3;
            else if (fn == 6'h2a) c.aluControl = 5'd4;
            else                  c.aluControl = 5'd0;
          end
      7:  begin c.regWrite = 1'b1; c.regDst = 2'b01; end
      8:  begin c.aluSrcA = 1'b1; c.aluControl = 5'd1; c.pcSrc = 2'b01; c.pcWrite = z; end
      9:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      10: c.regWrite = 1'b1;
      11: begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; end
      12: begin c.pcWrite = 1'b1; c.pcSrc = 2'b10; c.regWrite = 1'b1;
                c.regDst = 2'b10; c.memToReg = 2'b10; end
      13: begin c.pcWrite = 1'b1; c.pcSrc = 2'b11; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    load_seq(op, fn);
  endtask

  // one clock: apply inputs, compare against model, clock, advance model
  task automatic run_cycle(input logic mr, input logic z);
    memReady = mr;
    zero     = z;
    #1;
    check("state", {28'd0, state}, m_state());
    check("ctrl", {12'd0, act_c}, {12'd0, exp_ctrl(m_state(), mr, z, funct)});
    check("retired", {28'd0, retired}, m_ret % (1 << RETW));
    check("illegal", {31'd0, illegal}, {31'd0, m_ill});
    check("timeout", {31'd0, timeout}, {31'd0, m_tmo});
    @(posedge clock);
    model_step(mr);
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetN   = 1'b0;
    memReady = 1'b1;
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_strobes", {27'd0, pcWrite, irWrite, memRead, memWrite, regWrite}, 32'd0);
    check("rst_retired", {28'd0, retired}, 32'd0);
    check("rst_flags", {30'd0, illegal, timeout}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    m_idx = 0; m_wait = 0; m_ret = 0;
    m_ill = 1'b0; m_tmo = 1'b0; m_halt = 1'b0;
    load_seq(opcode, funct);
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cycles;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t vecs[13];
    logic [5:0] rops[16];
    logic [5:0] rfns[16];
    int r0, cnt, halt_cnt;

    vecs[0]  = '{6'h00, 6'h20, 1'b0, 4};  // add
    vecs[1]  = '{6'h00, 6'h22, 1'b0, 4};  // sub
    vecs[2]  = '{6'h00, 6'h24, 1'b0, 4};  // and
    vecs[3]  = '{6'h00, 6'h25, 1'b0, 4};  // or
    vecs[4]  = '{6'h00, 6'h2a, 1'b0, 4};  // slt
    vecs[5]  = '{6'h23, 6'h00, 1'b0, 5};  // lw
    vecs[6]  = '{6'h2b, 6'h00, 1'b0, 4};  // sw
    vecs[7]  = '{6'h04, 6'h00, 1'b1, 3};  // beq taken
    vecs[8]  = '{6'h04, 6'h00, 1'b0, 3};  // beq not taken
    vecs[9]  = '{6'h08, 6'h00, 1'b0, 4};  // addi
    vecs[10] = '{6'h02, 6'h00, 1'b0, 3};  // j
    vecs[11] = '{6'h03, 6'h00, 1'b0, 3};  // jal
    vecs[12] = '{6'h00, 6'h08, 1'b0, 3};  // jr

    for (int i = 0; i < 13; i++) begin
      rops[i] = vecs[i].op;
      rfns[i] = vecs[i].fn;
    end
    rops[13] = 6'h3f; rfns[13] = 6'h00;
    rops[14] = 6'h00; rfns[14] = 6'h01;
    rops[15] = 6'h23; rfns[15] = 6'h3f;

    set_instr(6'h00, 6'h20);
    @(negedge clock);
    do_reset();

    // latency table with memReady always high
    for (int i = 0; i < 13; i++) begin
      set_instr(vecs[i].op, vecs[i].fn);
      r0  = m_ret;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
        run_cycle(1'b1, vecs[i].z);
        cnt++;
        if (state == 4'd0 || state == 4'd15) break;
      end
      check("tbl_cycles", cnt, vecs[i].cycles);
      check("tbl_retired", {28'd0, retired}, (r0 + 1) % (1 << RETW));
    end

    // lw with two not-ready cycles in MEMRD: 0,1,2,3,3,3,4 then back to 0
    set_instr(6'h23, 6'h00);
    r0 = m_ret;
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    check("lw_in_memrd", {28'd0, state}, 32'd3);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    check("lw_memwb", {28'd0, state}, 32'd4);
    run_cycle(1'b1, 1'b0);
    check("lw_done", {28'd0, state}, 32'd0);
    check("lw_retired", {28'd0, retired}, (r0 + 1) % (1 << RETW));

    // illegal opcode halts with sticky flag; reset clears it
    set_instr(6'h3f, 6'h00);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    for (int c = 0; c < 4; c++) run_cycle(c[0], 1'b1);
    check("ill_state", {28'd0, state}, 32'd15);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    set_instr(6'h00, 6'h20);
    do_reset();

    // watchdog: four not-ready FETCH cycles reach MAXWAIT and halt
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b0);
    check("to_state", {28'd0, state}, 32'd15);
    check("to_flag", {31'd0, timeout}, 32'd1);
    do_reset();
    // memReady on the MAXWAIT cycle wins
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b0);
    run_cycle(1'b1, 1'b0);
    check("late_state", {28'd0, state}, 32'd1);
    check("late_flag", {31'd0, timeout}, 32'd0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);

    // randomized run, including mid-instruction resets and counter wrap
    halt_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halt) begin
        halt_cnt++;
        if (halt_cnt > 3) begin
          do_reset();
          halt_cnt = 0;
        end
      end else if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      if (!m_halt && m_seq[m_idx] == 0) begin
        int k;
        k = $urandom_range(0, 15);
        set_instr(rops[k], rfns[k]);
      end
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
